// File: rtl/finger_count_decoder.sv
// Synchronises, debounces and encodes N finger/switch lines into a registered count.
// Optional macro STICKY_ERR_EN makes err a sticky flag cleared by clr_err.
module finger_count_decoder #(
    parameter int N_FINGERS       = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CW             = $clog2(N_FINGERS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_FINGERS-1:0] fingers,
    input  logic                 mode,
    input  logic                 clr_err,
    output logic [CW-1:0]        count,
    output logic [N_FINGERS-1:0] stable,
    output logic                 thermo_ok,
    output logic                 err,
    output logic                 upd
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    // A thermometer code has no set bit above a clear bit, so v & (v+1) is zero.
    function automatic logic is_thermo(input logic [N_FINGERS-1:0] v);
        logic [N_FINGERS-1:0] inc;
        inc = v + 1'b1;
        return ((v & inc) == '0);
    endfunction

    logic [N_FINGERS-1:0] sync1_q;
    logic [N_FINGERS-1:0] sync2_q;
    logic [N_FINGERS-1:0] stable_q;
    logic [N_FINGERS-1:0] stable_d;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic                 thermo_q;
    logic                 thermo_d;
    logic                 err_q;
    logic                 err_d;
    logic                 upd_q;
    logic                 upd_d;
    logic [CW-1:0]        pop_s;
    logic [CW-1:0]        hi_s;

    // Two-flop synchroniser for every raw line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= fingers;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < N_FINGERS; g++) begin : g_line
        logic [DW-1:0] cnt_q;
        logic [DW-1:0] cnt_d;
        logic          nxt_s;

        // Flip only after DEBOUNCE_CYCLES consecutive differing cycles; any match restarts.
        always_comb begin
            cnt_d = cnt_q;
            nxt_s = stable_q[g];
            if (sync2_q[g] == stable_q[g]) begin
                cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
                cnt_d = '0;
                nxt_s = sync2_q[g];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        assign stable_d[g] = nxt_s;

        // Per-line debounce counter.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Encoder: popcount and highest-set-index+1 of the debounced pattern.
    always_comb begin
        pop_s = '0;
        hi_s  = '0;
        for (int i = 0; i < N_FINGERS; i++) begin
            pop_s = pop_s + CW'(stable_q[i]);
            if (stable_q[i]) begin
                hi_s = CW'(i + 1);
            end else begin
                hi_s = hi_s;
            end
        end
        if (mode) begin
            count_d = hi_s;
        end else begin
            count_d = pop_s;
        end
        thermo_d = is_thermo(stable_q);
        upd_d    = (count_d != count_q);
`ifdef STICKY_ERR_EN
        // A new violation wins over a simultaneous clear.
        err_d = ~thermo_d | (err_q & ~clr_err);
`else
        err_d = ~thermo_d;
`endif
    end

`ifndef STICKY_ERR_EN
    logic clr_err_unused_s;
    assign clr_err_unused_s = clr_err;
`endif

    // Debounced state and registered encoder outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= '0;
            count_q  <= '0;
            thermo_q <= 1'b1;
            err_q    <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            stable_q <= stable_d;
            count_q  <= count_d;
            thermo_q <= thermo_d;
            err_q    <= err_d;
            upd_q    <= upd_d;
        end
    end

    assign count     = count_q;
    assign stable    = stable_q;
    assign thermo_ok = thermo_q;
    assign err       = err_q;
    assign upd       = upd_q;

endmodule

// File: tb/tb_finger_count_decoder.sv
// Scenario bench for finger_count_decoder (defaults N_FINGERS=4, DEBOUNCE_CYCLES=4).
module tb_finger_count_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fingers;
    logic       mode;
    logic       clr_err;
    logic [2:0] count;
    logic [3:0] stable;
    logic       thermo_ok;
    logic       err;
    logic       upd;

    typedef struct packed {
        logic [2:0] c;
        logic [3:0] s;
        logic       t;
        logic       e;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   upd_cnt = 0;

    finger_count_decoder dut (
        .clk(clk), .rst(rst), .fingers(fingers), .mode(mode), .clr_err(clr_err),
        .count(count), .stable(stable), .thermo_ok(thermo_ok), .err(err), .upd(upd)
    );

    always #5 clk = ~clk;

    // Pulses are counted at the edge after they appear.
    always @(posedge clk) if (upd === 1'b1) upd_cnt++;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        exp_t e;
        rst = 1'b1; fingers = 4'b0000; mode = 1'b0; clr_err = 1'b0;
        sb.push_back('{3'd0, 4'b0000, 1'b1, 1'b0});
        cyc(2);
        e = sb.pop_front();
        checks++;
        if ({count, stable, thermo_ok, err} !== e) begin
            errors++;
            $display("FAIL reset: got c=%0d s=%b t=%b e=%b want c=%0d s=%b t=%b e=%b",
                     count, stable, thermo_ok, err, e.c, e.s, e.t, e.e);
        end
        checks++;
        if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b want 0", upd); end
        rst = 1'b0;
    endtask

    task automatic test_latency;
        exp_t e;
        fingers = 4'b0001;
        sb.push_back('{3'd1, 4'b0001, 1'b1, 1'b0});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 5) begin
                checks++;
                if (stable !== 4'b0000) begin errors++; $display("FAIL lat_early: stable=%b want 0000", stable); end
            end
            if (k == 6) begin
                checks++;
                if (stable !== 4'b0001 || count !== 3'd0) begin
                    errors++; $display("FAIL lat_stable: stable=%b count=%0d want 0001/0", stable, count);
                end
            end
            if (k == 7) begin
                e = sb.pop_front();
                checks++;
                if ({count, stable, thermo_ok, err} !== e) begin
                    errors++;
                    $display("FAIL lat_count: got c=%0d s=%b t=%b e=%b want c=%0d s=%b t=%b e=%b",
                             count, stable, thermo_ok, err, e.c, e.s, e.t, e.e);
                end
                checks++;
                if (upd !== 1'b1) begin errors++; $display("FAIL lat_upd: got %b want 1", upd); end
            end
            if (k == 8) begin
                checks++;
                if (upd !== 1'b0) begin errors++; $display("FAIL lat_upd_one: got %b want 0", upd); end
            end
        end
    endtask

    task automatic test_steps;
        logic [3:0] vals [3] = '{4'b0011, 4'b0111, 4'b1111};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            fingers = vals[i];
            sb.push_back('{3'(i + 2), vals[i], 1'b1, 1'b0});
            cyc(20);
            e = sb.pop_front();
            checks++;
            if ({count, stable, thermo_ok, err} !== e) begin
                errors++;
                $display("FAIL step%0d: got c=%0d s=%b t=%b e=%b want c=%0d s=%b t=%b e=%b",
                         i, count, stable, thermo_ok, err, e.c, e.s, e.t, e.e);
            end
        end
        checks++;
        if (upd_cnt !== 4) begin errors++; $display("FAIL step_upd_total: got %0d want 4", upd_cnt); end
    endtask

    task automatic test_glitch;
        exp_t e;
        int   base;
        logic seen;
        fingers = 4'b0011;
        cyc(20);
        base = upd_cnt;
        fingers = 4'b0111;
        cyc(3);
        fingers = 4'b0011;
        sb.push_back('{3'd2, 4'b0011, 1'b1, 1'b0});
        cyc(15);
        e = sb.pop_front();
        checks++;
        if ({count, stable, thermo_ok, err} !== e) begin
            errors++;
            $display("FAIL glitch3: got c=%0d s=%b t=%b e=%b want c=%0d s=%b t=%b e=%b",
                     count, stable, thermo_ok, err, e.c, e.s, e.t, e.e);
        end
        checks++;
        if (upd_cnt !== base) begin errors++; $display("FAIL glitch3_upd: got %0d pulses want 0", upd_cnt - base); end
        base = upd_cnt;
        seen = 1'b0;
        fingers = 4'b0111;
        cyc(4);
        fingers = 4'b0011;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (stable[2] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL glitch4_flip: stable[2] never 1, want 1"); end
        checks++;
        if (stable !== 4'b0011) begin errors++; $display("FAIL glitch4_final: stable=%b want 0011", stable); end
        checks++;
        if (upd_cnt - base !== 2) begin errors++; $display("FAIL glitch4_upd: got %0d want 2", upd_cnt - base); end
    endtask

    task automatic test_nonthermo;
        exp_t e;
        fingers = 4'b0101;
        mode = 1'b0;
        sb.push_back('{3'd2, 4'b0101, 1'b0, 1'b1});
        cyc(15);
        e = sb.pop_front();
        checks++;
        if ({count, stable, thermo_ok, err} !== e) begin
            errors++;
            $display("FAIL nonthermo_pop: got c=%0d s=%b t=%b e=%b want c=%0d s=%b t=%b e=%b",
                     count, stable, thermo_ok, err, e.c, e.s, e.t, e.e);
        end
        mode = 1'b1;
        sb.push_back('{3'd3, 4'b0101, 1'b0, 1'b1});
        cyc(1);
        e = sb.pop_front();
        checks++;
        if ({count, stable, thermo_ok, err} !== e) begin
            errors++;
            $display("FAIL nonthermo_hi: got c=%0d s=%b t=%b e=%b want c=%0d s=%b t=%b e=%b",
                     count, stable, thermo_ok, err, e.c, e.s, e.t, e.e);
        end
        checks++;
        if (upd !== 1'b1) begin errors++; $display("FAIL mode_upd: got %b want 1", upd); end
    endtask

    task automatic test_err_clear;
        exp_t e;
        fingers = 4'b0011;
`ifdef STICKY_ERR_EN
        sb.push_back('{3'd2, 4'b0011, 1'b1, 1'b1});
        cyc(15);
        e = sb.pop_front();
        checks++;
        if ({count, stable, thermo_ok, err} !== e) begin
            errors++;
            $display("FAIL sticky_hold: got c=%0d s=%b t=%b e=%b want c=%0d s=%b t=%b e=%b",
                     count, stable, thermo_ok, err, e.c, e.s, e.t, e.e);
        end
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL sticky_clr: err=%b want 0", err); end
        fingers = 4'b0101;
        cyc(15);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL sticky_setwins: err=%b want 1", err); end
        fingers = 4'b0011;
        cyc(15);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
`else
        sb.push_back('{3'd2, 4'b0011, 1'b1, 1'b0});
        cyc(15);
        e = sb.pop_front();
        checks++;
        if ({count, stable, thermo_ok, err} !== e) begin
            errors++;
            $display("FAIL err_follow: got c=%0d s=%b t=%b e=%b want c=%0d s=%b t=%b e=%b",
                     count, stable, thermo_ok, err, e.c, e.s, e.t, e.e);
        end
`endif
    endtask

    task automatic test_reset_mid;
        exp_t e;
        mode = 1'b0;
        fingers = 4'b0000;
        cyc(15);
        fingers = 4'b1111;
        cyc(4);
        rst = 1'b1;
        #1;
        sb.push_back('{3'd0, 4'b0000, 1'b1, 1'b0});
        e = sb.pop_front();
        checks++;
        if ({count, stable, thermo_ok, err, upd} !== {e, 1'b0}) begin
            errors++;
            $display("FAIL midreset: got c=%0d s=%b t=%b e=%b u=%b want c=0 s=0000 t=1 e=0 u=0",
                     count, stable, thermo_ok, err, upd);
        end
        cyc(2);
        rst = 1'b0;
        sb.push_back('{3'd4, 4'b1111, 1'b1, 1'b0});
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 5) begin
                checks++;
                if (stable !== 4'b0000) begin errors++; $display("FAIL rel_early: stable=%b want 0000", stable); end
            end
            if (k == 6) begin
                checks++;
                if (stable !== 4'b1111) begin errors++; $display("FAIL rel_stable: stable=%b want 1111", stable); end
            end
            if (k == 7) begin
                e = sb.pop_front();
                checks++;
                if ({count, stable, thermo_ok, err} !== e) begin
                    errors++;
                    $display("FAIL rel_count: got c=%0d s=%b t=%b e=%b want c=%0d s=%b t=%b e=%b",
                             count, stable, thermo_ok, err, e.c, e.s, e.t, e.e);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_steps();
        test_glitch();
        test_nonthermo();
        test_err_clear();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left: %0d entries want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/finger_count_decoder.md
Name: finger_count_decoder

Overview:
- Parametrised, clocked successor to the combinational finger decoder.
- Samples N raw finger/switch lines, synchronises and debounces each line, then encodes the stable pattern into a registered count.
- Flags patterns that are not thermometer codes and emits a one-cycle strobe when the count changes.
- Sits between the board switches/sensors and the display/ALU logic of the lab top level.

Parameters:
- N_FINGERS, 4, number of input lines (2..16).
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised line must differ from its stable value before the stable value flips (1..255).
- CW, $clog2(N_FINGERS+1), count width (derived localparam, not overridable).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- fingers  input  N_FINGERS  raw asynchronous lines; bit 0 is the first finger.
- mode  input  1  0 = popcount of stable lines; 1 = index+1 of highest stable set bit (0 if none).
- clr_err  input  1  clears sticky error (only used with STICKY_ERR_EN).
- count  output  CW  encoded result.
- stable  output  N_FINGERS  debounced line values.
- thermo_ok  output  1  stable pattern is a thermometer code (all ones contiguous from bit 0, including all-zero).
- err  output  1  non-thermometer indication (see Optional Feature).
- upd  output  1  one-cycle pulse when count changes value.

Behaviour:
- Reset (async assert, sync release): sync flops=0, debounce counters=0, stable=0, count=0, thermo_ok=1, err=0, upd=0.
- Stage 1, sync: two-flop synchroniser per line; sync2 = fingers delayed 2 edges.
- Stage 2, debounce, per line:
  - if sync2==stable, counter<=0;
  - else counter<=counter+1; when counter reaches DEBOUNCE_CYCLES-1 on a differing cycle, stable<=sync2 and counter<=0.
  - A differing run shorter than DEBOUNCE_CYCLES leaves stable unchanged and resets the counter on the first matching cycle.
  - Counter width $clog2(DEBOUNCE_CYCLES+1); never wraps.
- Stage 3, encode (registered from stable and mode):
  - mode=0: count = number of ones.
  - mode=1: count = highest set index+1.
  - thermo_ok registered from the same stable value.
  - upd=1 for exactly one cycle when the new count != the previous count.
  - A mode toggle that changes count also pulses upd.
- Latency: a clean level change on fingers held long enough is visible on stable 2+DEBOUNCE_CYCLES edges after the first edge that samples it, and on count/thermo_ok/upd one edge later. With defaults this is 7 edges.
- Simultaneous line changes debounce independently; count may pass through intermediate values, each producing its own upd pulse.
- Reset mid-debounce discards all partial counts; outputs return to reset values immediately.
- N_FINGERS=16, all ones: count=16 fits CW=5.

Optional Feature:
- Macro STICKY_ERR_EN.
- Defined:
  - err sets on the first encode cycle with thermo_ok=0 and holds until clr_err=1 at a rising edge.
  - If clr_err and a new violation occur in the same cycle, set wins and err stays 1.
- Undefined:
  - err = ~thermo_ok (registered, same timing).
  - clr_err is ignored.

Test Plan:
- Reset, then fingers=4'b0001 held 10 cycles, mode=0 -> stable=0001 and count=1 exactly 7 edges after first sample; upd high one cycle; thermo_ok=1.
- Step 0001->0011->0111->1111, 20 cycles each -> count 2,3,4 in sequence; four upd pulses total; err=0.
- Glitch fingers[2] high for 3 cycles (DEBOUNCE_CYCLES=4) -> stable, count and upd unchanged; a 4-cycle pulse must flip stable[2].
- fingers=4'b0101, mode=0 -> count=2, thermo_ok=0, err=1; switch mode=1 -> count=3 with an upd pulse.
- With STICKY_ERR_EN: after 0101, return to 0011 -> err stays 1 until clr_err pulse; err then 0. Without the macro, err falls with thermo_ok.
- Assert rst mid-debounce of 0000->1111 -> all outputs 0 (thermo_ok=1) immediately; after release the line needs a full 2+DEBOUNCE_CYCLES again.
